// File: rtl/fetch_redirect_unit.sv
// Fetch PC owner with F->D->EX prediction shadows; flushes and redirects fetch on an EX mispredict.
// Optional perf counters (perf_branches, perf_mispredicts) enabled by FETCH_REDIRECT_PERF_EN.
module fetch_redirect_unit #(
    parameter int unsigned         PC_BITS  = 32,
    parameter logic [PC_BITS-1:0]  RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               F_stall,
    input  logic               Itlb_stall,
    input  logic               MEM_stall,
    input  logic [PC_BITS-1:0] F_BP_target_pc,
    input  logic               F_BP_taken,
    input  logic               EX_brn,
    input  logic [PC_BITS-1:0] EX_alu_out,
    input  logic               EX_true_taken,
    output logic [PC_BITS-1:0] F_pc_va,
    output logic [PC_BITS-1:0] EX_pc,
    output logic               EX_valid,
    output logic               flush,
    output logic [PC_BITS-1:0] redirect_pc
`ifdef FETCH_REDIRECT_PERF_EN
   ,output logic [31:0]        perf_branches,
    output logic [31:0]        perf_mispredicts
`endif
);

    logic [PC_BITS-1:0] f_pc_q, f_pc_d;

    logic               d_valid_q, d_valid_d;
    logic [PC_BITS-1:0] d_pc_q, d_pc_d;
    logic               d_pred_taken_q, d_pred_taken_d;
    logic [PC_BITS-1:0] d_pred_next_q, d_pred_next_d;

    logic               ex_valid_q, ex_valid_d;
    logic [PC_BITS-1:0] ex_pc_q, ex_pc_d;
    logic               ex_pred_taken_q, ex_pred_taken_d;
    logic [PC_BITS-1:0] ex_pred_next_q, ex_pred_next_d;

    logic               fe_hold;
    logic [PC_BITS-1:0] ex_pc4;
    logic [PC_BITS-1:0] actual_next;
    logic [PC_BITS-1:0] pred_next;
    logic               mispredict;

    assign fe_hold     = F_stall | Itlb_stall | MEM_stall;
    assign ex_pc4      = ex_pc_q + PC_BITS'(4);
    assign actual_next = (EX_brn & EX_true_taken) ? EX_alu_out : ex_pc4;
    assign pred_next   = ex_pred_taken_q ? ex_pred_next_q : ex_pc4;
    // A frozen pipe must not resolve: EX will be re-evaluated once MEM_stall drops.
    assign mispredict  = ex_valid_q & ~MEM_stall & (actual_next != pred_next);

    assign flush       = mispredict;
    assign redirect_pc = mispredict ? actual_next : '0;
    assign F_pc_va     = f_pc_q;
    assign EX_pc       = ex_pc_q;
    assign EX_valid    = ex_valid_q;

    always_comb begin
        f_pc_d          = f_pc_q;
        d_valid_d       = d_valid_q;
        d_pc_d          = d_pc_q;
        d_pred_taken_d  = d_pred_taken_q;
        d_pred_next_d   = d_pred_next_q;
        ex_valid_d      = ex_valid_q;
        ex_pc_d         = ex_pc_q;
        ex_pred_taken_d = ex_pred_taken_q;
        ex_pred_next_d  = ex_pred_next_q;

        if (!MEM_stall) begin
            if (mispredict) begin
                f_pc_d     = actual_next;
                d_valid_d  = 1'b0;
                ex_valid_d = 1'b0;
            end else if (fe_hold) begin
                ex_valid_d      = d_valid_q;
                ex_pc_d         = d_pc_q;
                ex_pred_taken_d = d_pred_taken_q;
                ex_pred_next_d  = d_pred_next_q;
                d_valid_d       = 1'b0;
            end else begin
                f_pc_d          = F_BP_target_pc;
                d_valid_d       = 1'b1;
                d_pc_d          = f_pc_q;
                d_pred_taken_d  = F_BP_taken;
                d_pred_next_d   = F_BP_target_pc;
                ex_valid_d      = d_valid_q;
                ex_pc_d         = d_pc_q;
                ex_pred_taken_d = d_pred_taken_q;
                ex_pred_next_d  = d_pred_next_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            f_pc_q          <= RESET_PC;
            d_valid_q       <= 1'b0;
            d_pc_q          <= '0;
            d_pred_taken_q  <= 1'b0;
            d_pred_next_q   <= '0;
            ex_valid_q      <= 1'b0;
            ex_pc_q         <= '0;
            ex_pred_taken_q <= 1'b0;
            ex_pred_next_q  <= '0;
        end else begin
            f_pc_q          <= f_pc_d;
            d_valid_q       <= d_valid_d;
            d_pc_q          <= d_pc_d;
            d_pred_taken_q  <= d_pred_taken_d;
            d_pred_next_q   <= d_pred_next_d;
            ex_valid_q      <= ex_valid_d;
            ex_pc_q         <= ex_pc_d;
            ex_pred_taken_q <= ex_pred_taken_d;
            ex_pred_next_q  <= ex_pred_next_d;
        end
    end

`ifdef FETCH_REDIRECT_PERF_EN
    logic [31:0] perf_br_q, perf_br_d;
    logic [31:0] perf_mp_q, perf_mp_d;

    always_comb begin
        perf_br_d = perf_br_q;
        perf_mp_d = perf_mp_q;
        if (!MEM_stall && ex_valid_q && EX_brn && (perf_br_q != '1)) begin
            perf_br_d = perf_br_q + 32'd1;
        end
        if (mispredict && (perf_mp_q != '1)) begin
            perf_mp_d = perf_mp_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_br_q <= '0;
            perf_mp_q <= '0;
        end else begin
            perf_br_q <= perf_br_d;
            perf_mp_q <= perf_mp_d;
        end
    end

    assign perf_branches    = perf_br_q;
    assign perf_mispredicts = perf_mp_q;
`else
    // Counters are compiled out; no extra state or ports in this build.
`endif

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Scoreboard bench: driver pushes hand-computed expectations, a negedge monitor pops and compares.
module tb_fetch_redirect_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        F_stall = 1'b0, Itlb_stall = 1'b0, MEM_stall = 1'b0;
    logic [31:0] F_BP_target_pc = '0;
    logic        F_BP_taken = 1'b0;
    logic        EX_brn = 1'b0;
    logic [31:0] EX_alu_out = '0;
    logic        EX_true_taken = 1'b0;
    logic [31:0] F_pc_va, EX_pc, redirect_pc;
    logic        EX_valid, flush;
`ifdef FETCH_REDIRECT_PERF_EN
    logic [31:0] perf_branches, perf_mispredicts;
`endif

    fetch_redirect_unit #(.PC_BITS(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .F_stall(F_stall), .Itlb_stall(Itlb_stall), .MEM_stall(MEM_stall),
        .F_BP_target_pc(F_BP_target_pc), .F_BP_taken(F_BP_taken),
        .EX_brn(EX_brn), .EX_alu_out(EX_alu_out), .EX_true_taken(EX_true_taken),
        .F_pc_va(F_pc_va), .EX_pc(EX_pc), .EX_valid(EX_valid),
        .flush(flush), .redirect_pc(redirect_pc)
`ifdef FETCH_REDIRECT_PERF_EN
       ,.perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] f_pc;
        logic [31:0] ex_pc;
        logic        ex_v;
        logic        fl;
        logic [31:0] rd;
        logic [4:0]  m;
        string       nm;
    } exp_t;

    localparam logic [4:0] ALL  = 5'h1F;
    localparam logic [4:0] NOEP = 5'h1D;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] ef, input logic [31:0] eep, input logic eev,
                            input logic efl, input logic [31:0] erd, input logic [4:0] m, input string nm);
        exp_t e;
        e.f_pc = ef; e.ex_pc = eep; e.ex_v = eev; e.fl = efl; e.rd = erd; e.m = m; e.nm = nm;
        sbq.push_back(e);
    endtask

    // One cycle: after the edge, drive next inputs and queue the state expected until the next edge.
    task automatic cyc(input logic fs, input logic it, input logic ms,
                       input logic [31:0] tgt, input logic tk,
                       input logic brn, input logic [31:0] alu, input logic tt,
                       input logic [31:0] ef, input logic [31:0] eep, input logic eev,
                       input logic efl, input logic [31:0] erd, input logic [4:0] m, input string nm);
        @(posedge clk);
        #1;
        F_stall = fs; Itlb_stall = it; MEM_stall = ms;
        F_BP_target_pc = tgt; F_BP_taken = tk;
        EX_brn = brn; EX_alu_out = alu; EX_true_taken = tt;
        push_exp(ef, eep, eev, efl, erd, m, nm);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                if (e.m[0]) chk(e.nm, "F_pc_va",     F_pc_va,        e.f_pc);
                if (e.m[1]) chk(e.nm, "EX_pc",       EX_pc,          e.ex_pc);
                if (e.m[2]) chk(e.nm, "EX_valid",    {31'b0, EX_valid}, {31'b0, e.ex_v});
                if (e.m[3]) chk(e.nm, "flush",       {31'b0, flush},    {31'b0, e.fl});
                if (e.m[4]) chk(e.nm, "redirect_pc", redirect_pc,    e.rd);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : driver
        repeat (2) @(posedge clk);
        cyc(0,0,0, 32'h4, 0, 0, 32'h0, 0,   32'h0,   32'h0, 0, 0, 32'h0, ALL,  "reset");
        rst = 1'b1;
        cyc(0,0,0, 32'h8, 0, 0, 32'h0, 0,   32'h4,   32'h0, 0, 0, 32'h0, NOEP, "seq4");
        cyc(0,0,0, 32'hC, 0, 0, 32'h0, 0,   32'h8,   32'h0, 1, 0, 32'h0, ALL,  "seq8");
        cyc(0,0,0, 32'h10,0, 0, 32'h0, 0,   32'hC,   32'h4, 1, 0, 32'h0, ALL,  "seqC");
        cyc(0,0,0, 32'h40,1, 0, 32'h0, 0,   32'h10,  32'h8, 1, 0, 32'h0, ALL,  "fetch10");
        cyc(0,0,0, 32'h44,0, 0, 32'h0, 0,   32'h40,  32'hC, 1, 0, 32'h0, ALL,  "pred40");
        cyc(0,0,0, 32'h20,1, 1, 32'h40,1,   32'h44,  32'h10,1, 0, 32'h0, ALL,  "predok");
        cyc(0,0,0, 32'h24,0, 0, 32'h0, 0,   32'h20,  32'h40,1, 0, 32'h0, ALL,  "f20");
        cyc(0,0,0, 32'h28,0, 1, 32'h20,1,   32'h24,  32'h44,1, 0, 32'h0, ALL,  "br44ok");
        cyc(0,0,0, 32'h2C,0, 1, 32'h80,1,   32'h28,  32'h20,1, 1, 32'h80,ALL,  "takenmiss");
        cyc(0,0,0, 32'h84,0, 0, 32'h0, 0,   32'h80,  32'h0, 0, 0, 32'h0, NOEP, "redir80");
        cyc(0,0,0, 32'h30,1, 0, 32'h0, 0,   32'h84,  32'h0, 0, 0, 32'h0, NOEP, "post80");
        cyc(0,0,0, 32'h100,1,0, 32'h0, 0,   32'h30,  32'h80,1, 0, 32'h0, ALL,  "f30");
        cyc(0,0,0, 32'h104,0,1, 32'h30,1,   32'h100, 32'h84,1, 0, 32'h0, ALL,  "br84ok");
        cyc(0,0,0, 32'h108,0,0, 32'h0, 0,   32'h104, 32'h30,1, 1, 32'h34,ALL,  "aliasmiss");
        cyc(0,0,0, 32'h38,0, 0, 32'h0, 0,   32'h34,  32'h0, 0, 0, 32'h0, NOEP, "redir34");
        cyc(0,0,0, 32'h3C,0, 0, 32'h0, 0,   32'h38,  32'h0, 0, 0, 32'h0, NOEP, "f38");
        cyc(0,0,1, 32'h40,0, 1, 32'h200,1,  32'h3C,  32'h34,1, 0, 32'h0, ALL,  "memstall_a");
        cyc(0,0,1, 32'h40,0, 1, 32'h200,1,  32'h3C,  32'h34,1, 0, 32'h0, ALL,  "memstall_b");
        cyc(0,0,0, 32'h40,0, 1, 32'h200,1,  32'h3C,  32'h34,1, 1, 32'h200,ALL, "memrelease");
        cyc(0,0,0, 32'h204,0,0, 32'h0, 0,   32'h200, 32'h0, 0, 0, 32'h0, NOEP, "redir200");
        cyc(0,0,0, 32'h208,0,0, 32'h0, 0,   32'h204, 32'h0, 0, 0, 32'h0, NOEP, "f204");
        cyc(0,1,0, 32'h20C,0,1, 32'h300,1,  32'h208, 32'h200,1,1, 32'h300,ALL, "itlbmiss");
        cyc(0,0,0, 32'h304,0,0, 32'h0, 0,   32'h300, 32'h0, 0, 0, 32'h0, NOEP, "redir300");
        cyc(1,0,0, 32'h308,0,0, 32'h0, 0,   32'h304, 32'h0, 0, 0, 32'h0, NOEP, "f304");
        cyc(0,0,0, 32'h308,0,0, 32'h0, 0,   32'h304, 32'h300,1,0, 32'h0, ALL,  "fstall");
        cyc(0,0,0, 32'hFFFF_FFFC,1,0,32'h0,0, 32'h308, 32'h0, 0, 0, 32'h0, NOEP, "f308");
        cyc(0,0,0, 32'h40,1, 0, 32'h0, 0,   32'hFFFF_FFFC, 32'h304,1,0, 32'h0, ALL, "fwrap");
        cyc(0,0,0, 32'h44,0, 1, 32'hFFFF_FFFC,1, 32'h40, 32'h308,1,0, 32'h0, ALL, "br308ok");
        cyc(0,0,0, 32'h48,0, 1, 32'h40,0,   32'h44,  32'hFFFF_FFFC,1,1, 32'h0, ALL, "wrapmiss");
        cyc(0,0,0, 32'h4, 0, 0, 32'h0, 0,   32'h0,   32'h0, 0, 0, 32'h0, NOEP, "redir0");
        cyc(0,0,0, 32'h8, 0, 0, 32'h0, 0,   32'h4,   32'h0, 0, 0, 32'h0, NOEP, "f4");
        cyc(0,0,0, 32'hC, 0, 0, 32'h0, 0,   32'h8,   32'h0, 1, 0, 32'h0, ALL,  "f8");
        // Mid-cycle reset: F_pc_va advanced to 0xC at this edge, then rst falls with no edge in between.
        @(posedge clk);
        #2;
        rst = 1'b0;
        push_exp(32'h0, 32'h0, 0, 0, 32'h0, ALL, "asyncrst");
        @(posedge clk);
        #1;
        rst = 1'b1;
        push_exp(32'h0, 32'h0, 0, 0, 32'h0, ALL, "rsthold");
        cyc(0,0,0, 32'h10,0, 0, 32'h0, 0,   32'hC,   32'h0, 0, 0, 32'h0, NOEP, "rstexit");

        repeat (3) @(negedge clk);
        if (sbq.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
